// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus arbiter state encoding and defaults, plus the
// device/register addresses used by the sensor blocks.
package i2c_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANTED = 2'd1,
        ARB_GAP     = 2'd2
    } arb_state_t;

    localparam int DEF_BUS_FREE_CYCLES = 16;

    localparam logic [6:0] I2C_ADDR_TEMP_SENSOR = 7'h48;
    localparam logic [6:0] I2C_ADDR_IMU         = 7'h68;

    localparam logic [7:0] REG_TEMP_CONFIG      = 8'h01;
    localparam logic [7:0] REG_IMU_PWR_MGMT     = 8'h6B;
    localparam logic [7:0] REG_IMU_WHO_AM_I     = 8'h75;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit at or above ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N = 2,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                valid = 1'b1;
                index = W'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Grants one of NUM_REQ I2C masters exclusive use of the shared scl/sda pads,
// with a guaranteed bus-free gap between owners. ARB_TIMEOUT_EN bounds grants.
//
// state       | meaning
// ARB_IDLE    | bus released, arbitrating pending requests
// ARB_GRANTED | owner_id drives the pad pull-down enables
// ARB_GAP     | bus forced released for BUS_FREE_CYCLES cycles
module i2c_bus_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int BUS_FREE_CYCLES = DEF_BUS_FREE_CYCLES,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         scl_oe_in,
    input  logic [NUM_REQ-1:0]         sda_oe_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       busy,
    output logic                       scl_oe_out,
    output logic                       sda_oe_out,
    output logic                       timeout_err
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int GCW = (BUS_FREE_CYCLES > 1) ? $clog2(BUS_FREE_CYCLES) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("i2c_bus_arbiter: NUM_REQ must be 2..8");
    end
    if (BUS_FREE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
        $error("i2c_bus_arbiter: BUS_FREE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    arb_state_t         state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [GCW-1:0]     gap_q, gap_d;
    logic [NUM_REQ-1:0] owner_dec;
    logic [NUM_REQ-1:0] req_elig;
    logic               pick_valid;
    logic [IDW-1:0]     pick_idx;
    logic               release_now;
    logic               revoke_now;

    assign owner_dec   = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign release_now = (state_q == ARB_GRANTED) && !req[owner_q];

`ifdef ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCW-1:0]     tmo_q;
    logic [NUM_REQ-1:0] mask_q;
    logic               err_q;

    // A voluntary release on the terminal cycle wins over the revoke.
    assign revoke_now  = (state_q == ARB_GRANTED) && req[owner_q] && (tmo_q == '0);
    assign req_elig    = req & ~mask_q;
    assign timeout_err = err_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tmo_q  <= '0;
            mask_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == ARB_IDLE && pick_valid) begin
                tmo_q <= TCW'(TIMEOUT_CYCLES - 1);
            end else if (state_q == ARB_GRANTED && tmo_q != '0) begin
                tmo_q <= tmo_q - 1'b1;
            end
            // A revoked master stays masked until its req is seen low.
            mask_q <= (mask_q & req) | (revoke_now ? owner_dec : '0);
            if (revoke_now) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign revoke_now  = 1'b0;
    assign req_elig    = req;
    assign timeout_err = 1'b0;
`endif

    rr_pick #(
        .N (NUM_REQ),
        .W (IDW)
    ) u_rr_pick (
        .req   (req_elig),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_GRANTED;
                    owner_d = pick_idx;
                end
            end
            ARB_GRANTED: begin
                if (release_now || revoke_now) begin
                    state_d = ARB_GAP;
                    ptr_d   = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                    gap_d   = GCW'(BUS_FREE_CYCLES - 1);
                end
            end
            ARB_GAP: begin
                if (gap_q == '0) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant      = (state_q == ARB_GRANTED) ? owner_dec : '0;
    assign owner_id   = owner_q;
    assign busy       = (state_q != ARB_IDLE);
    assign scl_oe_out = (state_q == ARB_GRANTED) && scl_oe_in[owner_q];
    assign sda_oe_out = (state_q == ARB_GRANTED) && sda_oe_in[owner_q];

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one open-drain I2C bus (scl/sda) between NUM_REQ independent masters, e.g. the sensor-setup writer and the register poller.
- Each master requests the bus and receives an exclusive grant. Only the granted master's pull-down enables reach the pads.
- After each release, the bus is held idle for a guaranteed bus-free interval.
- Sits between the I2C master engines and the top-level tri-state pad drivers.

Parameters:
- NUM_REQ, 2, number of requesting masters; legal range 2..8.
- BUS_FREE_CYCLES, 16, clock cycles the bus is held released between owners; must be ≥1.
- TIMEOUT_CYCLES, 1000000, maximum grant length in clock cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clock  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request per master; held high for the whole transaction, dropped to release.
- scl_oe_in  in  NUM_REQ  per-master SCL pull-low enable.
- sda_oe_in  in  NUM_REQ  per-master SDA pull-low enable.
- grant  out  NUM_REQ  one-hot (or zero) grant.
- owner_id  out  $clog2(NUM_REQ)  index of the current or last owner.
- busy  out  1  high in GRANTED and GAP.
- scl_oe_out  out  1  SCL pull-low enable to the pad.
- sda_oe_out  out  1  SDA pull-low enable to the pad.
- timeout_err  out  1  sticky timeout flag; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: sampled only on a rising clock edge with reset_n=0.
  - Outputs: grant=0, owner_id=0, busy=0, scl_oe_out=0, sda_oe_out=0, timeout_err=0.
  - Internal: state=IDLE, round-robin pointer=0, gap counter=0.
- States: IDLE, GRANTED, GAP.
- IDLE:
  - If any req bit is high, pick the winner round-robin: first high bit searching upward from pointer, wrapping at NUM_REQ-1 to 0.
  - Next edge: grant[winner]=1, owner_id=winner, state=GRANTED.
  - Grant latency is exactly 1 cycle from req sampled high in IDLE.
  - With no requests, stay in IDLE with outputs released.
- GRANTED:
  - scl_oe_out=scl_oe_in[owner_id] and sda_oe_out=sda_oe_in[owner_id]. These are combinational muxes; no added latency.
  - Enables from all non-owners are ignored.
  - On the edge where req[owner_id] is sampled low:
    - grant goes to 0.
    - pointer=(owner_id+1) mod NUM_REQ.
    - gap counter loads BUS_FREE_CYCLES-1.
    - state=GAP.
  - Requests from other masters never pre-empt the owner.
- GAP:
  - grant=0 and both oe outputs forced to 0, so the bus floats high.
  - The counter decrements each cycle; at 0, state returns to IDLE.
  - Arbitration resumes in IDLE, so the minimum time from release to next grant is BUS_FREE_CYCLES+1 cycles.
- Boundary conditions:
  - A master that re-raises req during GAP is arbitrated normally. It has lowest priority relative to others because the pointer has advanced.
  - All NUM_REQ requesting simultaneously: grants rotate pointer order, one full transaction each.
  - req and its drop in the same cycle as the grant edge: owner receives a 1-cycle GRANTED, then GAP. No glitch on oe beyond that cycle.
  - reset_n low mid-transaction: oe outputs drop on that edge, releasing the bus. The masters themselves are reset by their own reset.
- Invariants: grant has at most one bit set. oe outputs are 0 whenever grant=0. owner_id holds its value through GAP and IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in GRANTED from grant assertion.
  - When it reaches TIMEOUT_CYCLES, the grant is revoked exactly as a release (pointer advances, enter GAP) and timeout_err is set.
  - timeout_err stays set until reset.
  - The revoked master must drop req before it can be re-granted: its req bit is masked until seen low for one cycle.
- Without the macro: no counter, no mask; timeout_err is constant 0; grants are unbounded.

Decomposition:
- Shared package i2c_pkg holds:
  - State encoding constants ARB_IDLE, ARB_GRANTED, ARB_GAP.
  - Default BUS_FREE_CYCLES.
  - I2C device and register address constants already used by the sensor blocks.
- One sub-module, rr_pick: combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: valid, index.
  - Reusable by future motor/servo bus schedulers.

Test Plan:
1. Reset, NUM_REQ=2, no req for 20 cycles -> grant=00, busy=0, oe outputs 0 throughout.
2. req=01 at cycle 5 -> grant=01 at cycle 6. Master 0 toggles sda_oe_in[0] and the toggle appears on sda_oe_out in the same cycle. Master 1 oe toggles are invisible.
3. req=11 simultaneously, each holds 10 cycles -> grant 01 (10 cycles), then 16 gap cycles with oe=0, then grant 10. Pointer wraps back to 0 afterwards.
4. Master 0 drops req and re-raises it during GAP while master 1 also requests -> master 1 is granted first.
5. reset_n=0 for one edge while grant=10 and scl_oe_out=1 -> next cycle grant=00, scl_oe_out=0, owner_id=0.
6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, master 0 holds req 200 cycles -> grant revoked after 50 cycles and timeout_err=1. Master 0 is not re-granted until req drops and rises again.
